// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store path: access sizes, byte-lane masks,
// the registered load context and the alignment rule.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_B0   = 4'b0001;
  localparam logic [3:0] LANE_LO   = 4'b0011;
  localparam logic [3:0] LANE_HI   = 4'b1100;
  localparam logic [3:0] LANE_ALL  = 4'b1111;

  // Everything needed to finish a CPU load one cycle after grant.
  typedef struct packed {
    logic [31:0] word;
    logic [1:0]  size;
    logic [1:0]  off;
    logic        uns;
  } ld_ctx_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering for CPU accesses: store enables/replicated data, misalign flag,
// and load lane extraction with sign/zero extension. Purely combinational, no backpressure.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_we,
  output logic [31:0] st_rep,
  output logic        misalign,
  input  ld_ctx_t     ld_ctx,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misalign = is_misaligned(st_size, st_off);
    st_we    = LANE_NONE;
    st_rep   = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_we  = LANE_B0 << st_off;
        st_rep = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_we  = st_off[1] ? LANE_HI : LANE_LO;
        st_rep = {2{st_data[15:0]}};
      end
      SZ_WORD: st_we = LANE_ALL;
      default: st_we = LANE_NONE;
    endcase
    // A misaligned access is still granted upstream; it just must not touch memory.
    if (misalign) st_we = LANE_NONE;
  end

  always_comb begin
    ld_byte = ld_ctx.word[{ld_ctx.off, 3'b000} +: 8];
    ld_half = ld_ctx.off[1] ? ld_ctx.word[31:16] : ld_ctx.word[15:0];
    ld_data = ld_ctx.word;
    case (ld_ctx.size)
      SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_ctx.uns}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_ctx.uns}}, ld_half};
      default: ld_data = ld_ctx.word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between CPU (priority) and DMA (starvation-guarded); grant is
// combinational, load data returns one cycle after grant; losers hold their request.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic        c_unsigned,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve_cnt;
  logic        starved;
  logic        cpu_win;
  logic        dma_win;
  logic        c_load;
  logic        d_load;
  logic [3:0]  st_we;
  logic [31:0] st_rep;
  logic        misalign;
  ld_ctx_t     c_ctx;
  logic [31:0] c_ld;
  logic [31:0] d_word;
  logic        c_pend;
  logic        d_pend;
  logic        err_pend;

  // Grants are masked during reset so every output sits at its reset value.
  assign starved = d_req && (starve_cnt == LIMIT);
  assign cpu_win = !rst && c_req && !starved;
  assign dma_win = !rst && d_req && !cpu_win;
  assign c_gnt   = cpu_win;
  assign d_gnt   = dma_win;
  assign c_load  = cpu_win && !c_we && !misalign;
  assign d_load  = dma_win && !d_we;

  lsu_align u_align (
    .st_size  (c_size),
    .st_off   (c_addr[1:0]),
    .st_data  (c_wdata),
    .st_we    (st_we),
    .st_rep   (st_rep),
    .misalign (misalign),
    .ld_ctx   (c_ctx),
    .ld_data  (c_ld)
  );

  always_comb begin
    mem_we    = LANE_NONE;
    mem_addr  = c_addr & ~32'h3;
    mem_wdata = st_rep;
    if (dma_win) begin
      mem_addr  = d_addr & ~32'h3;
      mem_wdata = d_wdata;
      if (d_we) mem_we = LANE_ALL;
    end else if (cpu_win && c_we) begin
      mem_we = st_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      c_pend     <= 1'b0;
      d_pend     <= 1'b0;
      err_pend   <= 1'b0;
      c_ctx      <= '0;
      d_word     <= '0;
    end else begin
      if (!d_req || dma_win) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
      c_pend   <= c_load;
      d_pend   <= d_load;
      err_pend <= cpu_win && misalign;
      // Context registers only move on a load so rdata holds between responses.
      if (c_load) begin
        c_ctx <= '{word: mem_rdata, size: c_size, off: c_addr[1:0], uns: c_unsigned};
      end
      if (d_load) d_word <= mem_rdata;
    end
  end

  assign c_rvalid = c_pend && !rst;
  assign d_rvalid = d_pend && !rst;
  assign c_err    = err_pend && !rst;
  assign c_rdata  = rst ? 32'h0 : c_ld;
  assign d_rdata  = rst ? 32'h0 : d_word;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised + directed bench for dmem_arbiter: driver predicts grants and responses from a
// byte-level memory model; a separate monitor pops the expected responses and compares them.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_unsigned;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid, c_err;
  logic [31:0] c_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_unsigned(c_unsigned),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural dmem: combinational read, lane writes at the rising edge.
  logic [31:0] dmem [0:255];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (mem_we[l]) dmem[mem_addr[9:2]][l*8 +: 8] <= mem_wdata[l*8 +: 8];
    end
  end
  assign mem_rdata = dmem[mem_addr[9:2]];

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        cq[$];
  rsp_t        dq[$];
  logic [31:0] ref_mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          streak = 0;
  logic [31:0] c_last = '0;
  logic [31:0] d_last = '0;

  logic        c_granted, d_granted;
  logic        obs_cg, obs_dg, obs_crv, obs_cerr;
  logic [3:0]  obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_crdata, obs_drdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the response due this cycle, otherwise expects quiet outputs and held rdata.
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      c_last = '0;
      d_last = '0;
    end else begin
      if (cq.size() > 0 && cq[0].due == cyc) begin
        e = cq.pop_front();
        chk("c_err", c_err, e.err);
        chk("c_rvalid", c_rvalid, !e.err);
        if (!e.err) begin
          chk("c_rdata", c_rdata, e.data);
          c_last = e.data;
        end else chk("c_rdata_hold_err", c_rdata, c_last);
      end else begin
        chk("c_idle_flags", {c_rvalid, c_err}, 2'b00);
        chk("c_rdata_hold", c_rdata, c_last);
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        e = dq.pop_front();
        chk("d_rvalid", d_rvalid, 1'b1);
        chk("d_rdata", d_rdata, e.data);
        d_last = e.data;
      end else begin
        chk("d_idle_rvalid", d_rvalid, 1'b0);
        chk("d_rdata_hold", d_rdata, d_last);
      end
    end
  end

  task automatic new_c(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic uns, input logic [31:0] wd);
    c_we = we; c_size = sz; c_addr = a; c_unsigned = uns; c_wdata = wd; c_req = 1'b1;
  endtask

  task automatic new_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
  endtask

  task automatic rand_c();
    logic [1:0]  sz;
    logic [31:0] a;
    sz = 2'($urandom_range(0, 3));
    if (sz == SZ_RSVD && $urandom_range(0, 3) != 0) sz = 2'($urandom_range(0, 2));
    a = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 5) != 0) begin
      if (sz == SZ_HALF) a[0] = 1'b0;
      else if (sz == SZ_WORD) a[1:0] = 2'b00;
    end
    new_c(1'($urandom_range(0, 1)), sz, a, 1'($urandom_range(0, 1)), $urandom());
  endtask

  task automatic rand_d();
    new_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom());
  endtask

  // One clock: at the falling edge predict grants, lanes and responses, then advance.
  task automatic step();
    logic [3:0]  exp_we;
    logic [31:0] exp_wd, w, v;
    logic [7:0]  b;
    logic [15:0] h;
    logic        mis;
    int          o, n, idx;
    rsp_t        e;
    @(negedge clk);
    obs_cg = c_gnt; obs_dg = d_gnt; obs_crv = c_rvalid; obs_cerr = c_err;
    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
    obs_crdata = c_rdata; obs_drdata = d_rdata;
    c_granted = 1'b0; d_granted = 1'b0;
    if (rst) begin
      streak = 0;
      chk("rst_gnt", {c_gnt, d_gnt}, 2'b00);
      chk("rst_flags", {c_rvalid, d_rvalid, c_err}, 3'b000);
      chk("rst_c_rdata", c_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_mem_we", mem_we, 4'b0000);
    end else begin
      c_granted = c_req && !(d_req && streak == LIMIT);
      d_granted = d_req && !c_granted;
      chk("c_gnt", c_gnt, c_granted);
      chk("d_gnt", d_gnt, d_granted);
      exp_we = 4'b0000;
      if (c_granted) begin
        o   = int'(c_addr[1:0]);
        idx = int'(c_addr[9:2]);
        mis = (c_size == SZ_RSVD) || (c_size == SZ_HALF && o % 2 != 0) ||
              (c_size == SZ_WORD && o != 0);
        chk("c_mem_addr", mem_addr, {c_addr[31:2], 2'b00});
        e.due = cyc + 1;
        e.err = mis;
        e.data = '0;
        if (!mis && c_we) begin
          n = (c_size == SZ_BYTE) ? 1 : (c_size == SZ_HALF) ? 2 : 4;
          for (int i = 0; i < n; i++) begin
            ref_mem[idx][(o + i)*8 +: 8] = c_wdata[i*8 +: 8];
            exp_we[o + i] = 1'b1;
          end
          exp_wd = (n == 1) ? {4{c_wdata[7:0]}} : (n == 2) ? {2{c_wdata[15:0]}} : c_wdata;
          chk("c_mem_wdata", mem_wdata, exp_wd);
        end else if (!mis) begin
          w = ref_mem[idx];
          b = w[o*8 +: 8];
          h = w[o*8 +: 16];
          if (c_size == SZ_BYTE) v = c_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
          else if (c_size == SZ_HALF) v = c_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
          else v = w;
          e.data = v;
        end
        if (mis || !c_we) cq.push_back(e);
      end else if (d_granted) begin
        idx = int'(d_addr[9:2]);
        chk("d_mem_addr", mem_addr, {d_addr[31:2], 2'b00});
        if (d_we) begin
          ref_mem[idx] = d_wdata;
          exp_we = 4'b1111;
          chk("d_mem_wdata", mem_wdata, d_wdata);
        end else begin
          e.err = 1'b0; e.data = ref_mem[idx]; e.due = cyc + 1;
          dq.push_back(e);
        end
      end else begin
        chk("idle_mem_addr", mem_addr, {c_addr[31:2], 2'b00});
      end
      chk("mem_we", mem_we, exp_we);
      if (d_req && !d_granted) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
      else streak = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_dg;
    logic cg_at4;
    rst = 1'b1; mem_clr = 1'b1;
    c_req = 0; c_we = 0; c_size = SZ_WORD; c_unsigned = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    @(posedge clk); #1;
    c_req = 1'b1; d_req = 1'b1;
    step();
    step();
    c_req = 1'b0; d_req = 1'b0; mem_clr = 1'b0; rst = 1'b0;
    step();

    // Byte store then signed and unsigned byte loads of the same address.
    new_c(1, SZ_BYTE, 32'h1F5, 0, 32'h0000_00A5);
    step(); c_req = 0;
    chk("tp_byte_we", obs_we, 4'b0010);
    chk("tp_byte_addr", obs_addr, 32'h1F4);
    chk("tp_byte_wdata", obs_wdata, 32'hA5A5_A5A5);
    new_c(0, SZ_BYTE, 32'h1F5, 0, 32'h0);
    step(); c_req = 0;
    step();
    chk("tp_lb_signed", obs_crdata, 32'hFFFF_FFA5);
    new_c(0, SZ_BYTE, 32'h1F5, 1, 32'h0);
    step(); c_req = 0;
    step();
    chk("tp_lb_unsigned", obs_crdata, 32'h0000_00A5);

    // Half store in the upper lanes, then signed half load.
    new_c(1, SZ_HALF, 32'h3EA, 0, 32'h0000_8001);
    step(); c_req = 0;
    chk("tp_half_we", obs_we, 4'b1100);
    new_c(0, SZ_HALF, 32'h3EA, 0, 32'h0);
    step(); c_req = 0;
    step();
    chk("tp_lh_signed", obs_crdata, 32'hFFFF_8001);

    // Misaligned word and reserved size: granted, no write, error pulse next cycle.
    for (int k = 0; k < 2; k++) begin
      new_c(0, (k == 0) ? SZ_WORD : SZ_RSVD, 32'h3E9, 0, 32'h0);
      step(); c_req = 0;
      chk("tp_mis_gnt", obs_cg, 1'b1);
      chk("tp_mis_we", obs_we, 4'b0000);
      step();
      chk("tp_mis_err", obs_cerr, 1'b1);
      chk("tp_mis_rvalid", obs_crv, 1'b0);
    end

    // Simultaneous requests with a clear counter: CPU first, DMA next cycle.
    new_c(0, SZ_WORD, 32'h000, 0, 32'h0);
    new_d(0, 32'h1F4, 32'h0);
    step(); c_req = 0;
    chk("tp_both_cgnt", obs_cg, 1'b1);
    chk("tp_both_dgnt", obs_dg, 1'b0);
    step(); d_req = 0;
    chk("tp_dma_gnt", obs_dg, 1'b1);
    step();
    chk("tp_dma_rdata", obs_drdata, 32'h0000_A500);

    // Starvation guard with the CPU requesting continuously.
    rand_c();
    new_d(0, 32'h100, 32'h0);
    first_dg = -1; cg_at4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_dg && first_dg < 0) first_dg = i;
      if (i == 4) cg_at4 = obs_cg;
      if (c_granted) rand_c();
      if (d_granted) d_req = 0;
    end
    chk("starve_first_dgnt", first_dg, 4);
    chk("starve_cgnt_cycle4", cg_at4, 1'b0);

    // Random traffic; requests are held until granted.
    c_req = 0; d_req = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_req && $urandom_range(0, 3) != 0) rand_c();
      if (!d_req && $urandom_range(0, 2) == 0) rand_d();
      step();
      if (c_granted) c_req = 0;
      if (d_granted) d_req = 0;
    end
    c_req = 0; d_req = 0;
    step();
    step();

    // Reset in the cycle after a granted load discards its response.
    new_c(0, SZ_WORD, 32'h1F4, 0, 32'h0);
    step(); c_req = 0;
    rst = 1'b1; cq.delete(); dq.delete();
    step();
    rst = 1'b0;
    step();
    new_c(0, SZ_WORD, 32'h1F4, 0, 32'h0);
    new_d(0, 32'h3E8, 32'h0);
    step(); c_req = 0;
    chk("post_rst_cpu_wins", {obs_cg, obs_dg}, 2'b10);
    step(); d_req = 0;
    step();
    step();

    chk("c_queue_drained", cq.size(), 0);
    chk("d_queue_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
